// File: rtl/fifo_pkg.sv
// Shared sizing defaults for the single-clock FIFO and its storage array.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH = 16;

  // Address bits needed to index a power-of-two deep array.
  function automatic int fifo_addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read, no reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = fifo_addr_width(DEFAULT_FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered full/empty flags and
// a one-cycle data_valid pulse per accepted read.
module async_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_en,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  data_valid
);

  localparam int ADDR_WIDTH = fifo_addr_width(FIFO_DEPTH);
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

  // Handshake: a write is taken when write_en && !full, a read when
  // read_en && !empty, both sampled on the same rising edge; reset wins.
  logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic                  wr_acc, rd_acc;
  logic                  out_zero;
  logic [DATA_WIDTH-1:0] rd_data;

  assign wr_acc     = rst & write_en & ~full;
  assign rd_acc     = rst & read_en & ~empty;
  assign wr_ptr_nxt = wr_ptr + PTR_WIDTH'(wr_acc);
  assign rd_ptr_nxt = rd_ptr + PTR_WIDTH'(rd_acc);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      data_valid <= 1'b0;
      out_zero   <= 1'b1;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      empty      <= (wr_ptr_nxt == rd_ptr_nxt);
      full       <= (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]) &&
                    (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]);
      data_valid <= rd_acc;
      if (rd_acc) out_zero <= 1'b0;
    end
  end

  // The array read register has no reset, so data_out is forced to zero
  // from reset until the first accepted read refreshes it.
  assign data_out = out_zero ? '0 : rd_data;

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data(data_in),
    .rd_en  (rd_acc),
    .rd_addr(rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_async_fifo.sv
// Directed and randomized bench for async_fifo against a queue-based model.
module tb_async_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] data_in;
  logic         write_en;
  logic         read_en;
  logic [W-1:0] data_out;
  logic         full;
  logic         empty;
  logic         data_valid;

  async_fifo #(.DATA_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .write_en  (write_en),
    .read_en   (read_en),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .data_valid(data_valid)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_out;
  logic         exp_valid;
  int           checks;
  int           errors;
  string        phase;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
  task automatic step(input logic r, input logic we, input logic re, input logic [W-1:0] din);
    bit wacc, racc;
    rst = r; write_en = we; read_en = re; data_in = din;
    racc = r && re && (exp_q.size() != 0);
    wacc = r && we && (exp_q.size() != DEPTH);
    @(posedge clk);
    #1;
    if (!r) begin
      exp_q.delete();
      exp_out   = '0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = racc;
      if (racc) exp_out = exp_q.pop_front();
      if (wacc) exp_q.push_back(din);
    end
    check("data_valid", 32'(data_valid), 32'(exp_valid));
    check("data_out",   32'(data_out),   32'(exp_out));
    check("full",       32'(full),       32'(exp_q.size() == DEPTH));
    check("empty",      32'(empty),      32'(exp_q.size() == 0));
  endtask

  initial begin
    checks = 0; errors = 0;
    exp_out = '0; exp_valid = 1'b0;
    rst = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = '0;

    phase = "reset";
    step(1'b0, 1'b1, 1'b1, 8'hAA);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    phase = "fill";
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 8'(i));

    phase = "write_when_full";
    step(1'b1, 1'b1, 1'b0, 8'hFF);

    phase = "drain";
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
    phase = "read_when_empty";
    step(1'b1, 1'b0, 1'b1, 8'h00);
    check("hold_0f", 32'(data_out), 32'h0F);

    phase = "preload";
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 8'(100 + i));
    phase = "simul_rw";
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'(200 + i));
      check("occupancy", 32'(exp_q.size()), 32'd8);
    end
    check("last_simul", 32'(data_out), 32'd207);
    phase = "flush";
    while (exp_q.size() != 0) step(1'b1, 1'b0, 1'b1, 8'h00);

    phase = "gated_write";
    for (int i = 0; i < 20; i++)
      step(1'b1, exp_q.size() != DEPTH, 1'b0, 8'(50 + i));
    check("stored", 32'(exp_q.size()), 32'(DEPTH));

    phase = "full_rw";
    step(1'b1, 1'b1, 1'b1, 8'hEE);
    check("full_rw_out", 32'(data_out), 32'd50);

    phase = "gated_read";
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b0, exp_q.size() != 0, 8'h00);

    phase = "empty_rw";
    step(1'b1, 1'b1, 1'b1, 8'h33);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    check("empty_rw_out", 32'(data_out), 32'h33);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = (i % 100 < 50) ? 75 : 25;
      step(1'b1, $urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
           8'($urandom_range(0, 255)));
    end

    phase = "mid_reset";
    while (exp_q.size() != 0) step(1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'(10 + i));
    step(1'b0, 1'b1, 1'b1, 8'h77);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h5A);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    check("post_reset_read", 32'(data_out), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
